// File: rtl/eth_crc_if.sv
`default_nettype none
// ============================================================================
//  Module   : eth_crc_if
//  Purpose  : Beat stream into, and frame results out of, the Ethernet
//             CRC-32 engine.
//  Signals  : in_valid/in_sop/in_eop/in_abort/in_data  - beat stream
//             out_valid/out_crc/out_ok/out_len/out_err - frame result
//  Modports : master - stream source / result sink
//             slave  - the CRC engine
//  Revision : 1.0 - initial release
// ============================================================================
interface eth_crc_if #(
  parameter int DATA_W = 4,
  parameter int LEN_W  = 16
);
  logic              in_valid;
  logic              in_sop;
  logic              in_eop;
  logic              in_abort;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic [31:0]       out_crc;
  logic              out_ok;
  logic [LEN_W-1:0]  out_len;
  logic              out_err;

  modport master (
    output in_valid, in_sop, in_eop, in_abort, in_data,
    input  out_valid, out_crc, out_ok, out_len, out_err
  );

  modport slave (
    input  in_valid, in_sop, in_eop, in_abort, in_data,
    output out_valid, out_crc, out_ok, out_len, out_err
  );
endinterface
`default_nettype wire

// File: rtl/eth_crc_engine.sv
`default_nettype none
// ============================================================================
//  Module   : eth_crc_engine
//  Purpose  : Streaming reflected CRC-32 over SOP/EOP-delimited frames.
//             Produces the FCS (out_crc) and the residue check (out_ok) in
//             the same pass, plus the frame length in beats.
//  Ports    : clk  - clock
//             rst  - synchronous active-high reset
//             bus  - eth_crc_if.slave (beat stream in, frame result out)
//  Revision : 1.0 - initial release
// ============================================================================
module eth_crc_engine #(
  parameter int          DATA_W   = 4,
  parameter logic [31:0] CRC_POLY = 32'hEDB88320,
  parameter logic [31:0] CRC_INIT = 32'hFFFFFFFF,
  parameter logic [31:0] XOR_OUT  = 32'hFFFFFFFF,
  parameter logic [31:0] RESIDUE  = 32'hDEBB20E3,
  parameter int          LEN_W    = 16
) (
  input  logic     clk,
  input  logic     rst,
  eth_crc_if.slave bus
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;

  logic [0:0]       r_state;
  logic [31:0]      r_crc;
  logic [LEN_W-1:0] r_cnt;

  logic [31:0]      w_seed;
  logic [31:0]      w_next;
  logic [LEN_W-1:0] w_cnt_next;
  logic             w_accept;
  logic             w_err;

  // DATA_W serial LFSR steps unrolled into one combinational update, bit 0 first.
  function automatic logic [31:0] f_crc_update(input logic [31:0] crc,
                                               input logic [DATA_W-1:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < DATA_W; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ CRC_POLY;
      else             c = c >> 1;
    end
    return c;
  endfunction

  always_comb begin
    w_seed     = bus.in_sop ? CRC_INIT : r_crc;
    w_next     = f_crc_update(w_seed, bus.in_data);
    // A SOP beat always restarts the count; otherwise saturate at all-ones.
    if (bus.in_sop)  w_cnt_next = LEN_W'(1);
    else if (&r_cnt) w_cnt_next = r_cnt;
    else             w_cnt_next = r_cnt + LEN_W'(1);
    // Beats are consumed when they start a frame or continue an open one.
    w_accept   = bus.in_valid && (bus.in_sop || (r_state == S_ACTIVE));
    // Violations: data outside a frame, or a new SOP inside an open frame.
    w_err      = bus.in_valid &&
                 (((r_state == S_IDLE)   && !bus.in_sop) ||
                  ((r_state == S_ACTIVE) &&  bus.in_sop));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_crc         <= CRC_INIT;
      r_cnt         <= '0;
      bus.out_valid <= 1'b0;
      bus.out_err   <= 1'b0;
      bus.out_ok    <= 1'b0;
      bus.out_crc   <= '0;
      bus.out_len   <= '0;
    end else begin
      bus.out_valid <= 1'b0;
      bus.out_err   <= 1'b0;
      if (bus.in_abort) begin
        // Abort wins over any beat this cycle; held results stay untouched.
        r_state <= S_IDLE;
        r_crc   <= CRC_INIT;
        r_cnt   <= '0;
      end else begin
        if (w_err) bus.out_err <= 1'b1;
        if (w_accept) begin
          r_crc <= w_next;
          r_cnt <= w_cnt_next;
          if (bus.in_eop) begin
            bus.out_valid <= 1'b1;
            bus.out_crc   <= w_next ^ XOR_OUT;
            bus.out_ok    <= (w_next == RESIDUE);
            bus.out_len   <= w_cnt_next;
            r_state       <= S_IDLE;
          end else begin
            r_state       <= S_ACTIVE;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eth_crc_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_eth_crc_engine
//  Purpose  : Scoreboard bench for eth_crc_engine, one instance with 4-bit
//             beats and one with 8-bit beats, driven with "123456789".
//  Revision : 1.0 - initial release
// ============================================================================
module tb_eth_crc_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] crc;
    logic        chk_crc;
    logic        ok;
    int          len;
    int          cyc;
  } exp_t;

  exp_t sb4[$];
  exp_t sb8[$];
  exp_t e4;
  exp_t e8;
  int   err4 = 0;
  int   err8 = 0;

  logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
  logic [7:0] fcs [4] = '{8'h26, 8'h39, 8'hF4, 8'hCB};
  logic [3:0] nq[$];
  logic [7:0] bq[$];

  eth_crc_if #(.DATA_W(4), .LEN_W(16)) if4();
  eth_crc_if #(.DATA_W(8), .LEN_W(16)) if8();

  eth_crc_engine #(.DATA_W(4), .LEN_W(16)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
  eth_crc_engine #(.DATA_W(8), .LEN_W(16)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!rst && if4.out_valid) begin
      if (sb4.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_valid4: got out_valid=1 expected none");
      end else begin
        e4 = sb4.pop_front();
        if (e4.chk_crc) chk("crc4", if4.out_crc, e4.crc);
        chk("ok4",  {31'b0, if4.out_ok}, {31'b0, e4.ok});
        chk("len4", 32'(if4.out_len), 32'(e4.len));
        chk("cyc4", 32'(cyc), 32'(e4.cyc));
      end
    end
    if (!rst && if4.out_err) err4++;
  end

  always @(negedge clk) begin
    if (!rst && if8.out_valid) begin
      if (sb8.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_valid8: got out_valid=1 expected none");
      end else begin
        e8 = sb8.pop_front();
        if (e8.chk_crc) chk("crc8", if8.out_crc, e8.crc);
        chk("ok8",  {31'b0, if8.out_ok}, {31'b0, e8.ok});
        chk("len8", 32'(if8.out_len), 32'(e8.len));
        chk("cyc8", 32'(cyc), 32'(e8.cyc));
      end
    end
    if (!rst && if8.out_err) err8++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat4(input logic sop, input logic eop, input logic [3:0] d);
    if4.in_valid = 1'b1; if4.in_sop = sop; if4.in_eop = eop; if4.in_data = d;
    @(posedge clk); #1;
    if4.in_valid = 1'b0; if4.in_sop = 1'b0; if4.in_eop = 1'b0;
  endtask

  task automatic beat8(input logic sop, input logic eop, input logic [7:0] d);
    if8.in_valid = 1'b1; if8.in_sop = sop; if8.in_eop = eop; if8.in_data = d;
    @(posedge clk); #1;
    if8.in_valid = 1'b0; if8.in_sop = 1'b0; if8.in_eop = 1'b0;
  endtask

  // Message as nibbles, low nibble first; optional FCS and single-bit flip.
  task automatic load4(input logic with_fcs, input int flip);
    nq.delete();
    for (int i = 0; i < 9; i++) begin nq.push_back(msg[i][3:0]); nq.push_back(msg[i][7:4]); end
    if (with_fcs)
      for (int i = 0; i < 4; i++) begin nq.push_back(fcs[i][3:0]); nq.push_back(fcs[i][7:4]); end
    if (flip >= 0) nq[flip] = nq[flip] ^ 4'h1;
  endtask

  task automatic load8(input logic with_fcs);
    bq.delete();
    for (int i = 0; i < 9; i++) bq.push_back(msg[i]);
    if (with_fcs) for (int i = 0; i < 4; i++) bq.push_back(fcs[i]);
  endtask

  // Result appears the cycle after the EOP beat is sampled.
  task automatic frame4(input logic [31:0] crc, input logic chk_crc, input logic ok);
    exp_t e;
    e.crc = crc; e.chk_crc = chk_crc; e.ok = ok; e.len = nq.size(); e.cyc = cyc + nq.size();
    sb4.push_back(e);
    for (int i = 0; i < nq.size(); i++) beat4(i == 0, i == nq.size() - 1, nq[i]);
  endtask

  task automatic frame8(input logic [31:0] crc, input logic chk_crc, input logic ok);
    exp_t e;
    e.crc = crc; e.chk_crc = chk_crc; e.ok = ok; e.len = bq.size(); e.cyc = cyc + bq.size();
    sb8.push_back(e);
    for (int i = 0; i < bq.size(); i++) beat8(i == 0, i == bq.size() - 1, bq[i]);
  endtask

  task automatic chk_zero4(input string tag);
    chk({tag, "_valid"}, {31'b0, if4.out_valid}, 32'h0);
    chk({tag, "_err"},   {31'b0, if4.out_err},   32'h0);
    chk({tag, "_ok"},    {31'b0, if4.out_ok},    32'h0);
    chk({tag, "_crc"},   if4.out_crc,            32'h0);
    chk({tag, "_len"},   32'(if4.out_len),       32'h0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    if4.in_valid = 0; if4.in_sop = 0; if4.in_eop = 0; if4.in_abort = 0; if4.in_data = '0;
    if8.in_valid = 0; if8.in_sop = 0; if8.in_eop = 0; if8.in_abort = 0; if8.in_data = '0;
    wait_cycles(3);
    chk_zero4("reset");
    rst = 1'b0;
    wait_cycles(1);

    // Plain check value, then with FCS appended (good residue), then corrupted.
    load4(1'b0, -1); frame4(32'hCBF43926, 1'b1, 1'b0);
    load4(1'b1, -1); frame4(32'h2144DF1C, 1'b1, 1'b1);
    load4(1'b1, 3);  frame4(32'h0, 1'b0, 1'b0);
    wait_cycles(2);

    // Stray beat while idle: error only.
    beat4(1'b0, 1'b0, 4'h5);
    wait_cycles(2);
    chk("err_idle_beat", 32'(err4), 32'd1);

    // SOP five beats into a frame: error, then restarted frame completes.
    load4(1'b0, -1);
    for (int i = 0; i < 5; i++) beat4(i == 0, 1'b0, nq[i]);
    frame4(32'hCBF43926, 1'b1, 1'b0);
    wait_cycles(2);
    chk("err_resop", 32'(err4), 32'd2);

    // Abort mid-frame on a cycle that also carries an EOP beat.
    load4(1'b0, -1);
    beat4(1'b1, 1'b0, nq[0]); beat4(1'b0, 1'b0, nq[1]); beat4(1'b0, 1'b0, nq[2]);
    if4.in_abort = 1'b1;
    beat4(1'b0, 1'b1, nq[3]);
    if4.in_abort = 1'b0;
    chk("abort_len_held", 32'(if4.out_len), 32'd18);
    frame4(32'hCBF43926, 1'b1, 1'b0);
    wait_cycles(2);
    chk("err_abort", 32'(err4), 32'd2);

    // Reset mid-frame clears everything; next frame is still correct.
    for (int i = 0; i < 4; i++) beat4(i == 0, 1'b0, nq[i]);
    rst = 1'b1;
    wait_cycles(1);
    chk_zero4("midrst");
    rst = 1'b0;
    frame4(32'hCBF43926, 1'b1, 1'b0);
    wait_cycles(2);

    // 8-bit beats: back-to-back frames, then residue check.
    load8(1'b0);
    frame8(32'hCBF43926, 1'b1, 1'b0);
    frame8(32'hCBF43926, 1'b1, 1'b0);
    load8(1'b1);
    frame8(32'h2144DF1C, 1'b1, 1'b1);

    for (int i = 0; i < 50 && (sb4.size() != 0 || sb8.size() != 0); i++) wait_cycles(1);
    chk("pending4", 32'(sb4.size()), 32'd0);
    chk("pending8", 32'(sb8.size()), 32'd0);
    chk("err8_none", 32'(err8), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
